weight_load_ctrl: RTL

Sequencer that programs the 10×10 binary weight array of the drowsiness-detector Hopfield layer one row at a time. It accepts rows from an upstream valid/ready stream and drives the weight store's write-enable, 5-bit address and row data, placing the matrix in one of three address banks (base 0, 10 or 20). It signals completion and, optionally, checks that the loaded matrix is a legal Hopfield matrix before completion is reported.

---
 rtl/wt_ctrl_pkg.sv | 11 +
 rtl/wt_sym_checker.sv | 46 ++++
 rtl/weight_load_ctrl.sv | 93 +++++++++
 3 files changed

// File: rtl/wt_ctrl_pkg.sv
// wt_ctrl_pkg: shared sizes, error codes and state type for weight_load_ctrl.
package wt_ctrl_pkg;
  localparam int N_NEURON = 10;
  localparam int N_BANK = 3;
  localparam int ADDR_W = 5;
  localparam int ROW_W = $clog2(N_NEURON);
  localparam logic [1:0] ERR_NONE = 2'b00;
  localparam logic [1:0] ERR_BANK = 2'b01;
  localparam logic [1:0] ERR_MATRIX = 2'b10;
  typedef enum logic [2:0] {IDLE, LOAD, FLUSH, CHECK, DONE} state_t;
endpackage

// File: rtl/wt_sym_checker.sv
// wt_sym_checker: shadows loaded rows, then checks symmetry and zero diagonal one row per cycle.
// Only built with WT_SYM_CHECK_EN defined.
`ifdef WT_SYM_CHECK_EN
module wt_sym_checker
  import wt_ctrl_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                capture,
  input  logic [ROW_W-1:0]    row_idx,
  input  logic [N_NEURON-1:0] row_data,
  input  logic                clear,
  input  logic                start,
  output logic                done,
  output logic                fail
);
  logic [N_NEURON-1:0] shadow [N_NEURON];
  logic [N_NEURON-1:0] col;
  logic [ROW_W-1:0] cnt;
  logic run, acc, bad;
  always_comb begin
    for (int k = 0; k < N_NEURON; k++) col[k] = shadow[k][cnt];
    bad = (shadow[cnt] != col) || shadow[cnt][cnt];
  end
  assign done = run && cnt == ROW_W'(N_NEURON - 1);
  assign fail = acc || bad;
  always_ff @(posedge clk)
    if (capture) shadow[row_idx] <= row_data;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      run <= 1'b0;
      cnt <= '0;
      acc <= 1'b0;
    end else if (clear) begin
      run <= 1'b0;
    end else if (start) begin
      run <= 1'b1;
      cnt <= '0;
      acc <= 1'b0;
    end else if (run) begin
      acc <= acc || bad;
      cnt <= cnt + 1'b1;
      if (done) run <= 1'b0;
    end
endmodule
`endif

// File: rtl/weight_load_ctrl.sv
// weight_load_ctrl: streams a 10x10 Hopfield weight matrix row by row into one of three store banks.
// Define WT_SYM_CHECK_EN to verify symmetry and a zero diagonal before completion.
module weight_load_ctrl
  import wt_ctrl_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [1:0]          bank,
  input  logic                abort,
  input  logic                row_valid,
  input  logic [N_NEURON-1:0] row_data,
  output logic                row_ready,
  output logic                wt_we,
  output logic [ADDR_W-1:0]   wt_addr,
  output logic [N_NEURON-1:0] wt_data,
  output logic                busy,
  output logic                done,
  output logic                err,
  output logic [1:0]          err_code
);
  state_t state;
  logic [ROW_W-1:0] row;
  logic [ADDR_W-1:0] base;
  logic accept;
  assign row_ready = state == LOAD && !abort;
  assign accept = row_valid && row_ready;
  assign busy = state != IDLE;
  assign done = state == DONE;
`ifdef WT_SYM_CHECK_EN
  logic chk_done, chk_fail;
  wt_sym_checker u_chk (
    .clk      (clk),
    .rst_n    (rst_n),
    .capture  (accept),
    .row_idx  (row),
    .row_data (row_data),
    .clear    (abort),
    .start    (state == FLUSH && !abort),
    .done     (chk_done),
    .fail     (chk_fail)
  );
`endif
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      row <= '0;
      base <= '0;
      wt_we <= 1'b0;
      wt_addr <= '0;
      wt_data <= '0;
      err <= 1'b0;
      err_code <= ERR_NONE;
    end else begin
      wt_we <= accept;
      if (accept) begin
        wt_addr <= base + ADDR_W'(row);
        wt_data <= row_data;
        row <= row + 1'b1;
      end
      case (state)
        IDLE: if (start) begin
          if (bank < 2'(N_BANK)) begin
            state <= LOAD;
            base <= ADDR_W'(bank) * ADDR_W'(N_NEURON);
            row <= '0;
            err <= 1'b0;
            err_code <= ERR_NONE;
          end else begin
            state <= DONE;
            err <= 1'b1;
            err_code <= ERR_BANK;
          end
        end
        LOAD: if (abort) state <= IDLE;
          else if (accept && row == ROW_W'(N_NEURON - 1)) state <= FLUSH;
`ifdef WT_SYM_CHECK_EN
        FLUSH: state <= abort ? IDLE : CHECK;
        CHECK: if (abort) state <= IDLE;
          else if (chk_done) begin
            state <= DONE;
            if (chk_fail) begin
              err <= 1'b1;
              err_code <= ERR_MATRIX;
            end
          end
`else
        FLUSH: state <= abort ? IDLE : DONE;
`endif
        default: state <= IDLE;
      endcase
    end
endmodule
